// File: rtl/mem_lsu.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_lsu : MEM-stage load/store unit (req/gnt/rvalid data bus, aligned     |
// |           lanes, sign/zero-extended loads). Optional LSU_MISALIGN_EXP_EN. |
// | Revision: 1.0 - initial release                                           |
// +--------------------------------------------------------------------------+
module mem_lsu #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pipe_flush,
  input  logic            mem_valid,
  input  logic            mem_we,
  input  logic            mem_re,
  input  logic [2:0]      mem_funct3,
  input  logic [XLEN-1:0] mem_addr,
  input  logic [XLEN-1:0] mem_wdata,
  output logic            dbus_req,
  output logic            dbus_we,
  output logic [XLEN-1:0] dbus_addr,
  output logic [XLEN-1:0] dbus_wdata,
  output logic [3:0]      dbus_be,
  input  logic            dbus_gnt,
  input  logic            dbus_rvalid,
  input  logic [XLEN-1:0] dbus_rdata,
  output logic            store_hand_suc,
  output logic            load_hand_suc,
  output logic [XLEN-1:0] load_data,
  output logic            lsu_misal_exp,
  output logic            lsu_busy
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_RESP  = 3'd2,
    S_DONE  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

`ifdef LSU_MISALIGN_EXP_EN
  localparam logic c_misal_trap_en = 1'b1;
`else
  localparam logic c_misal_trap_en = 1'b0;
`endif

  state_t          r_state;
  state_t          w_state_nxt;
  logic [XLEN-1:0] r_addr;
  logic [XLEN-1:0] r_wdata;
  logic [XLEN-1:0] r_load_data;
  logic [2:0]      r_funct3;
  logic [3:0]      r_be;
  logic            r_we;
  logic            r_misal;

  logic            w_start;
  logic            w_misal;
  logic            w_misal_trap;
  logic [1:0]      w_lo;
  logic [3:0]      w_be;
  logic [XLEN-1:0] w_lane_wdata;
  logic [XLEN-1:0] w_shifted;
  logic [XLEN-1:0] w_ld_ext;
  logic            w_ld_update;

  // Decode of the MEM-stage request; only consulted while idle.
  assign w_start      = mem_valid & (mem_we | mem_re) & ~pipe_flush;
  assign w_misal      = mem_funct3[1] ? (|mem_addr[1:0]) : (mem_funct3[0] & mem_addr[0]);
  assign w_misal_trap = c_misal_trap_en & w_misal;

  always_comb begin
    w_lo         = mem_addr[1:0];
    w_be         = 4'b0001 << mem_addr[1:0];
    w_lane_wdata = {4{mem_wdata[7:0]}};
    if (mem_funct3[1]) begin
      w_lo         = 2'b00;
      w_be         = 4'b1111;
      w_lane_wdata = mem_wdata;
    end else if (mem_funct3[0]) begin
      w_lo[0]      = 1'b0;
      w_be         = 4'b0011 << {mem_addr[1], 1'b0};
      w_lane_wdata = {2{mem_wdata[15:0]}};
    end
  end

  // Low address bits were forced to natural alignment, so a plain lane shift works.
  assign w_shifted = dbus_rdata >> {r_addr[1:0], 3'b000};

  always_comb begin
    w_ld_ext = w_shifted;
    if (r_funct3[1:0] == 2'b00)
      w_ld_ext = {{(XLEN-8){~r_funct3[2] & w_shifted[7]}}, w_shifted[7:0]};
    else if (r_funct3[1:0] == 2'b01)
      w_ld_ext = {{(XLEN-16){~r_funct3[2] & w_shifted[15]}}, w_shifted[15:0]};
  end

  assign w_ld_update = (r_state == S_RESP) & dbus_rvalid & ~pipe_flush & ~r_we;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (w_start) w_state_nxt = w_misal_trap ? S_DONE : S_REQ;
      S_REQ: begin
        // A flushed request the bus already accepted still owes a response.
        if (pipe_flush)    w_state_nxt = dbus_gnt ? S_DRAIN : S_IDLE;
        else if (dbus_gnt) w_state_nxt = S_RESP;
      end
      S_RESP: begin
        if (dbus_rvalid)     w_state_nxt = pipe_flush ? S_IDLE : S_DONE;
        else if (pipe_flush) w_state_nxt = S_DRAIN;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      S_DRAIN: if (dbus_rvalid) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr   <= '0;
      r_wdata  <= '0;
      r_funct3 <= 3'b000;
      r_be     <= 4'b0000;
      r_we     <= 1'b0;
      r_misal  <= 1'b0;
    end else if ((r_state == S_IDLE) && w_start) begin
      r_addr   <= {mem_addr[XLEN-1:2], w_lo};
      r_wdata  <= w_lane_wdata;
      r_funct3 <= mem_funct3;
      r_be     <= w_be;
      r_we     <= mem_we;
      r_misal  <= w_misal_trap;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           r_load_data <= '0;
    else if (w_ld_update) r_load_data <= w_ld_ext;
  end

  assign dbus_req       = (r_state == S_REQ);
  assign dbus_we        = r_we;
  assign dbus_addr      = {r_addr[XLEN-1:2], 2'b00};
  assign dbus_wdata     = r_wdata;
  assign dbus_be        = r_be;
  assign store_hand_suc = (r_state == S_DONE) & r_we;
  assign load_hand_suc  = (r_state == S_DONE) & ~r_we;
  assign load_data      = r_load_data;
  assign lsu_busy       = (r_state != S_IDLE);

`ifdef LSU_MISALIGN_EXP_EN
  assign lsu_misal_exp  = (r_state == S_DONE) & r_misal;
`else
  assign lsu_misal_exp  = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_lsu.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mem_lsu : self-checking bench for mem_lsu against a byte-level model.  |
// | Revision: 1.0 - initial release                                           |
// +--------------------------------------------------------------------------+
module tb_mem_lsu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pipe_flush = 1'b0;
  logic        mem_valid = 1'b0;
  logic        mem_we = 1'b0;
  logic        mem_re = 1'b0;
  logic [2:0]  mem_funct3 = 3'b000;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic        dbus_req, dbus_we;
  logic [31:0] dbus_addr, dbus_wdata;
  logic [3:0]  dbus_be;
  logic        dbus_gnt = 1'b0;
  logic        dbus_rvalid = 1'b0;
  logic [31:0] dbus_rdata = '0;
  logic        store_hand_suc, load_hand_suc, lsu_misal_exp, lsu_busy;
  logic [31:0] load_data;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_ld = '0;

  mem_lsu #(.XLEN(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .pipe_flush(pipe_flush),
    .mem_valid(mem_valid), .mem_we(mem_we), .mem_re(mem_re),
    .mem_funct3(mem_funct3), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
    .dbus_wdata(dbus_wdata), .dbus_be(dbus_be), .dbus_gnt(dbus_gnt),
    .dbus_rvalid(dbus_rvalid), .dbus_rdata(dbus_rdata),
    .store_hand_suc(store_hand_suc), .load_hand_suc(load_hand_suc),
    .load_data(load_data), .lsu_misal_exp(lsu_misal_exp), .lsu_busy(lsu_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: accesses described as byte ranges within the word.
  function automatic int acc_size(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic bit is_misal(input logic [2:0] f3, input logic [31:0] a);
    return (int'(a[1:0]) % acc_size(f3)) != 0;
  endfunction

  function automatic int lane_off(input logic [2:0] f3, input logic [31:0] a);
    int o = int'(a[1:0]);
    return o - (o % acc_size(f3));
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] a);
    logic [3:0] be = '0;
    int off = lane_off(f3, a);
    int sz  = acc_size(f3);
    for (int i = 0; i < 4; i++) be[i] = (i >= off) && (i < off + sz);
    return be;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] r = '0;
    int sz = acc_size(f3);
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % sz) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] rd);
    longint v = 0;
    int off = lane_off(f3, a);
    int sz  = acc_size(f3);
    for (int k = 0; k < sz; k++) v += longint'(rd[8*(off+k) +: 8]) << (8*k);
    if (!f3[2] && sz < 4 && v >= (longint'(1) << (8*sz - 1))) v -= (longint'(1) << (8*sz));
    return v[31:0];
  endfunction

  task automatic garble_mem_inputs();
    mem_valid  = 1'($urandom_range(0, 1));
    mem_we     = 1'($urandom_range(0, 1));
    mem_re     = 1'($urandom_range(0, 1));
    mem_funct3 = 3'($urandom);
    mem_addr   = $urandom;
    mem_wdata  = $urandom;
  endtask

  task automatic quiet_mem_inputs();
    mem_valid = 1'b0; mem_we = 1'b0; mem_re = 1'b0;
  endtask

  // One full transaction; gd/rvd are gnt/rvalid wait cycles, fl flushes in RESP.
  task automatic run_op(input bit st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] rd,
                        input int gd, input int rvd, input bit fl);
    mem_valid = 1'b1; mem_we = st; mem_re = !st;
    mem_funct3 = f3; mem_addr = a; mem_wdata = wd;
    @(posedge clk); #1;
    quiet_mem_inputs();
`ifdef LSU_MISALIGN_EXP_EN
    if (is_misal(f3, a)) begin
      check_val("mis_req", dbus_req, 1'b0);
      check_val("mis_ld_suc", load_hand_suc, !st);
      check_val("mis_st_suc", store_hand_suc, st);
      check_val("mis_exp", lsu_misal_exp, 1'b1);
      check_val("mis_ld_data", load_data, exp_ld);
      @(posedge clk); #1;
      check_val("mis_idle_busy", lsu_busy, 1'b0);
      check_val("mis_idle_exp", lsu_misal_exp, 1'b0);
      return;
    end
`endif
    for (int i = 0; i <= gd; i++) begin
      check_val("req", dbus_req, 1'b1);
      check_val("req_we", dbus_we, st);
      check_val("req_addr", dbus_addr, {a[31:2], 2'b00});
      check_val("req_be", dbus_be, model_be(f3, a));
      if (st) check_val("req_wdata", dbus_wdata, model_wdata(f3, wd));
      garble_mem_inputs();
      dbus_gnt = (i == gd);
      @(posedge clk); #1;
    end
    dbus_gnt = 1'b0;
    for (int i = 0; i <= rvd; i++) begin
      check_val("resp_req", dbus_req, 1'b0);
      check_val("resp_busy", lsu_busy, 1'b1);
      check_val("resp_suc", {store_hand_suc, load_hand_suc}, 2'b00);
      garble_mem_inputs();
      pipe_flush  = fl && (i == 0);
      dbus_rvalid = (i == rvd);
      dbus_rdata  = (i == rvd) ? rd : $urandom;
      @(posedge clk); #1;
    end
    pipe_flush = 1'b0; dbus_rvalid = 1'b0;
    quiet_mem_inputs();
    if (fl) begin
      check_val("fl_suc", {store_hand_suc, load_hand_suc}, 2'b00);
      check_val("fl_busy", lsu_busy, 1'b0);
      check_val("fl_ld_data", load_data, exp_ld);
    end else begin
      if (!st) exp_ld = model_load(f3, a, rd);
      check_val("done_ld_suc", load_hand_suc, !st);
      check_val("done_st_suc", store_hand_suc, st);
      check_val("done_exp", lsu_misal_exp, 1'b0);
      check_val("done_ld_data", load_data, exp_ld);
      @(posedge clk); #1;
      check_val("post_suc", {store_hand_suc, load_hand_suc}, 2'b00);
      check_val("post_busy", lsu_busy, 1'b0);
    end
  endtask

  initial begin
    logic [2:0] f3;
    bit         st;
    #1;
    check_val("rst_req", dbus_req, 1'b0);
    check_val("rst_we", dbus_we, 1'b0);
    check_val("rst_addr", dbus_addr, 32'h0);
    check_val("rst_wdata", dbus_wdata, 32'h0);
    check_val("rst_be", dbus_be, 4'b0000);
    check_val("rst_suc", {store_hand_suc, load_hand_suc, lsu_misal_exp, lsu_busy}, 4'b0000);
    check_val("rst_ld_data", load_data, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(1'b0, 3'b010, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 0, 0, 1'b0);
    check_val("tp_lw", load_data, 32'hDEAD_BEEF);
    run_op(1'b0, 3'b000, 32'h0000_0103, 32'h0, 32'h8011_2233, 0, 0, 1'b0);
    check_val("tp_lb", load_data, 32'hFFFF_FF80);
    run_op(1'b0, 3'b100, 32'h0000_0103, 32'h0, 32'h8011_2233, 1, 1, 1'b0);
    check_val("tp_lbu", load_data, 32'h0000_0080);
    run_op(1'b1, 3'b001, 32'h0000_0202, 32'h0000_ABCD, 32'h0, 3, 0, 1'b0);
    run_op(1'b0, 3'b010, 32'h0000_0400, 32'h0, 32'h1234_5678, 0, 2, 1'b1);
    check_val("tp_flush_ld", load_data, 32'h0000_0080);
    run_op(1'b0, 3'b010, 32'h0000_0101, 32'h0, 32'hCAFE_F00D, 0, 0, 1'b0);
    run_op(1'b0, 3'b101, 32'h0000_0503, 32'h0, 32'h8765_4321, 0, 1, 1'b0);

    // Flush while the request is still waiting for a grant.
    mem_valid = 1'b1; mem_re = 1'b1; mem_funct3 = 3'b010; mem_addr = 32'h600;
    @(posedge clk); #1;
    quiet_mem_inputs();
    check_val("flreq_pre", dbus_req, 1'b1);
    pipe_flush = 1'b1;
    @(posedge clk); #1;
    pipe_flush = 1'b0;
    check_val("flreq_req", dbus_req, 1'b0);
    check_val("flreq_busy", lsu_busy, 1'b0);

    // Flush together with a new request, then a non-memory instruction.
    mem_valid = 1'b1; mem_re = 1'b1; pipe_flush = 1'b1;
    @(posedge clk); #1;
    pipe_flush = 1'b0; mem_re = 1'b0; mem_we = 1'b0;
    check_val("flidle_busy", lsu_busy, 1'b0);
    @(posedge clk); #1;
    quiet_mem_inputs();
    check_val("nonmem_busy", {lsu_busy, dbus_req}, 2'b00);

    // Reset while in REQ; a stray response afterwards must be ignored.
    mem_valid = 1'b1; mem_re = 1'b1; mem_funct3 = 3'b010; mem_addr = 32'h700;
    @(posedge clk); #1;
    quiet_mem_inputs();
    check_val("rstreq_pre", dbus_req, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_val("rstreq_req", dbus_req, 1'b0);
    check_val("rstreq_busy", lsu_busy, 1'b0);
    check_val("rstreq_ld", load_data, 32'h0);
    exp_ld = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    dbus_rvalid = 1'b1; dbus_rdata = 32'h5555_AAAA;
    @(posedge clk); #1;
    dbus_rvalid = 1'b0;
    check_val("rstreq_stray", {lsu_busy, store_hand_suc, load_hand_suc}, 3'b000);
    check_val("rstreq_stray_ld", load_data, 32'h0);
    run_op(1'b1, 3'b010, 32'h0000_0804, 32'h1357_9BDF, 32'h0, 1, 2, 1'b0);

    for (int n = 0; n < 60; n++) begin
      st = 1'($urandom_range(0, 1));
      if (st) f3 = 3'($urandom_range(0, 2));
      else begin
        case ($urandom_range(0, 4))
          0: f3 = 3'b000; 1: f3 = 3'b001; 2: f3 = 3'b010; 3: f3 = 3'b100; default: f3 = 3'b101;
        endcase
      end
      run_op(st, f3, $urandom, $urandom, $urandom, $urandom_range(0, 3),
             $urandom_range(0, 3), $urandom_range(0, 7) == 0);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_lsu.md
# mem_lsu

Load/store unit for the MEM stage: accepts the valid load or store held in the MEM stage and runs it on the data bus through a req/gnt/rvalid handshake. Produces the one-cycle `store_hand_suc` / `load_hand_suc` completion strobes that release the MEM→WB pipeline register. Also returns byte-aligned, sign- or zero-extended load data as the stage's write-back value.

## Interface
Parameters:
- `XLEN`, 32, data/address width; only 32 is supported.

Ports:
- `clk` input 1: clock.
- `rst_n` input 1: reset, asynchronous, active-low.
- `pipe_flush` input 1: kill the MEM-stage instruction.
- `mem_valid` input 1: MEM stage holds a valid instruction.
- `mem_we` input 1: the instruction is a store.
- `mem_re` input 1: the instruction is a load.
- `mem_funct3` input 3: access size/sign (RV32I LB/LH/LW/LBU/LHU, SB/SH/SW encodings).
- `mem_addr` input XLEN: effective byte address.
- `mem_wdata` input XLEN: store data in bits [7:0]/[15:0]/[31:0].
- `dbus_req` output 1: bus request.
- `dbus_we` output 1: bus write.
- `dbus_addr` output XLEN: word-aligned bus address.
- `dbus_wdata` output XLEN: store data shifted to its byte lanes.
- `dbus_be` output 4: byte enables.
- `dbus_gnt` input 1: request accepted this cycle.
- `dbus_rvalid` input 1: response (read data or write ack).
- `dbus_rdata` input XLEN: read data.
- `store_hand_suc` output 1: store completed (1-cycle pulse).
- `load_hand_suc` output 1: load completed (1-cycle pulse).
- `load_data` output XLEN: extended load result, valid while `load_hand_suc`=1 and held until the next load completes.
- `lsu_misal_exp` output 1: misaligned access exception, qualified by hand_suc.
- `lsu_busy` output 1: state ≠ IDLE.

## Operation
- FSM states and transitions:
  - IDLE → REQ: `mem_valid & (mem_we|mem_re)` and access aligned.
  - REQ → RESP: on `dbus_gnt`.
  - RESP → DONE: on `dbus_rvalid`.
  - DONE → IDLE: unconditionally.
  - DRAIN → IDLE: on `dbus_rvalid`.
- Op latching: on the IDLE→REQ transition, address, we, funct3 and wdata are latched. Bus outputs are driven from these registers, never directly from MEM-stage inputs.
- `dbus_req`=1 only in REQ. The bus fields are held stable until `dbus_gnt`.
- `dbus_addr` = {addr[31:2],2'b00}.
- `dbus_be` / `dbus_wdata` for stores:
  - Byte: `dbus_be` = 4'b0001<<addr[1:0]; wdata byte replicated to all lanes.
  - Half: `dbus_be` = 4'b0011<<{addr[1],1'b0}; wdata half replicated to both halves.
  - Word: `dbus_be` = 4'b1111.
  - Loads use the same byte-enable pattern.
- Load data: in the cycle of `dbus_rvalid` in RESP, `load_data` is registered. The addressed byte/half is selected by addr[1:0], then sign-extended (LB/LH) or zero-extended (LBU/LHU); LW is passed through.
- Completion strobes (DONE only): `store_hand_suc` = 1 if the op was a store; `load_hand_suc` = 1 if it was a load. Exactly one cycle per instruction.
- Non-memory instruction (`mem_we`=`mem_re`=0): the LSU stays IDLE and emits nothing.
- Misalignment: halfword with addr[0]≠0, or word with addr[1:0]≠0. Handling depends on the configuration (see Configuration).
- Flush:
  - In REQ: drop the request, go to IDLE with no strobe. `dbus_req` is low in the next cycle.
  - In RESP: go to DRAIN. Wait for the outstanding `dbus_rvalid`, discard it, produce no strobe, and do not update `load_data`.
  - In DONE: the strobe is still driven that cycle, but downstream flush logic has priority.
  - `pipe_flush` in IDLE together with a new request: no transaction starts.
- `mem_valid`/`mem_*` inputs are ignored in every state except IDLE.

## Timing
- Reset values:
  - `dbus_req`, `dbus_we`, `store_hand_suc`, `load_hand_suc`, `lsu_misal_exp`, `lsu_busy` = 0.
  - `dbus_addr`, `dbus_wdata`, `load_data` = 0.
  - `dbus_be` = 4'b0000.
  - FSM in IDLE.
- Reset mid-transaction returns to IDLE immediately; in-flight bus responses after reset are ignored.
- Best case, with `dbus_gnt` and `dbus_rvalid` each high on first opportunity:
  - Cycle 0: IDLE, request seen.
  - Cycle 1: REQ, gnt.
  - Cycle 2: RESP, rvalid.
  - Cycle 3: DONE, hand_suc = 1.
  - Back-to-back memory ops therefore complete at most one per 4 cycles.
- A `dbus_rvalid` that arrives in the same cycle as `dbus_gnt` is not permitted by the bus.
- Completion strobes and `lsu_misal_exp` are registered state decodes, with no combinational path from `dbus_*` inputs.

## Configuration
- `LSU_MISALIGN_EXP_EN` defined:
  - A misaligned access goes IDLE→DONE directly with no bus transaction.
  - DONE asserts the matching hand_suc together with `lsu_misal_exp`=1 for one cycle.
  - `load_data` is unchanged.
- `LSU_MISALIGN_EXP_EN` undefined:
  - `lsu_misal_exp` is tied to 0.
  - Misaligned accesses are issued with addr low bits forced to natural alignment: addr[0]=0 for halfword, addr[1:0]=0 for word.

## Test plan
- LW at 0x100, gnt and rvalid immediate, rdata=0xDEADBEEF → `dbus_be`=1111, `load_hand_suc` pulses in cycle 3, `load_data`=0xDEADBEEF.
- LB at 0x103, rdata=0x80112233 → `dbus_be`=1000, `load_data`=0xFFFFFF80. LBU at the same address and data → `load_data`=0x00000080.
- SH at 0x202, wdata=0x0000ABCD, gnt held low 3 cycles → `dbus_req` held with addr=0x200, be=1100, wdata=0xABCDABCD; `store_hand_suc` pulses one cycle after rvalid.
- Load granted, `pipe_flush` in RESP, rvalid 2 cycles later → no hand_suc, `load_data` unchanged, `lsu_busy` low the cycle after rvalid.
- LW at 0x101 with `LSU_MISALIGN_EXP_EN` → no `dbus_req`, `load_hand_suc`=`lsu_misal_exp`=1 in cycle 1. Without the macro → bus addr=0x100, no exception.
- `rst_n` asserted in REQ → `dbus_req`=0 immediately, FSM IDLE; after release a new SW completes normally.
